apb_timer_master: RTL and testbench
===================================

Name: apb_timer_master

Overview:
- Upstream APB requester that drives the timer's APB slave port.
- Accepts simple host requests (write or read, address, data) through a valid/ready handshake and buffers them in a small FIFO.
- Issues each request as a compliant APB3 transfer (SETUP then ACCESS), waits for PREADY, and returns read data and error status as a one-cycle response pulse.
- Adds an ACCESS-phase timeout so a stuck slave cannot hang the host.

Parameters:
- ADDR_W, 8, width of req_addr and PADDR.
- DATA_W, 8, width of write and read data.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 16, maximum ACCESS cycles before forced termination; 0 disables the timeout.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  FIFO can accept a request (= !full).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target register address.
- req_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR or timeout for this transfer.
- busy  out  1  FIFO not empty or FSM not IDLE.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-transfer:
  - state = IDLE and the FIFO is empty.
  - All outputs are 0, except req_ready = 1.
  - Any in-flight transfer is abandoned and no response is generated for it.
- FIFO:
  - A push occurs on an edge where req_valid && req_ready.
  - req_ready is derived from the registered full flag only. A push is refused when the FIFO is full, even if a pop happens on the same edge.
  - A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
  - Order is strictly FIFO.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - PSEL = 0 and PENABLE = 0.
  - If the FIFO is not empty: pop the head, register PADDR, PWRITE and PWDATA, then go to SETUP.
- SETUP:
  - PSEL = 1 and PENABLE = 0.
  - Clear the timeout counter.
  - Go to ACCESS unconditionally.
- ACCESS:
  - PSEL = 1 and PENABLE = 1.
  - PADDR, PWRITE and PWDATA stay stable throughout.
  - On an edge with PREADY = 1, the transfer completes:
    - Next cycle: rsp_valid = 1.
    - rsp_rdata = PRDATA for a read, or 0 for a write.
    - rsp_err = PSLVERR.
  - PRDATA and PSLVERR are sampled only on that edge.
  - After completion: go to SETUP with the next FIFO entry popped (back-to-back, PSEL stays 1 and PENABLE drops), or go to IDLE if the FIFO is empty.
- Timeout:
  - The counter increments on each ACCESS edge with PREADY = 0.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT, the transfer terminates exactly as a completion, with rsp_err = 1 and rsp_rdata = 0.
- Response:
  - There is no backpressure.
  - rsp_valid is high for exactly one cycle per popped request.
  - rsp_rdata and rsp_err hold their values until the next response.
- APB outputs between transfers: PADDR, PWRITE and PWDATA hold their last values, and PSEL is 0.
- Latency, with the FIFO empty, the FSM in IDLE and PREADY = 1, for a push at edge k:
  - PSEL rises after edge k+1.
  - PENABLE rises after edge k+2.
  - The transfer completes at edge k+3.
  - rsp_valid is high in the cycle after edge k+3.
- Throughput: back-to-back transfers take 2 cycles each with zero wait states.

Test Plan:
- Write 0x90 to addr 0x00 (TCR), PREADY tied 1:
  - PSEL/PENABLE timing matches the latency above.
  - PWDATA = 0x90 and PWRITE = 1 throughout SETUP/ACCESS.
  - One rsp_valid with rsp_err = 0 and rsp_rdata = 0.
- Read addr 0x02 with the slave returning PRDATA = 0x5A and PREADY low for 3 ACCESS cycles:
  - PENABLE is high for 4 cycles.
  - rsp_rdata = 0x5A and rsp_err = 0.
  - PADDR is stable for the whole transfer.
- Push 5 requests on consecutive cycles with PREADY = 0 initially:
  - req_ready goes low once 4 entries are held.
  - After PREADY = 1, responses arrive in push order, back-to-back, with no IDLE cycles between them.
- PREADY stuck 0 with TIMEOUT = 16:
  - rsp_valid comes after 16 ACCESS cycles with rsp_err = 1 and rsp_rdata = 0.
  - The next queued request then proceeds normally.
- Slave asserts PSLVERR = 1 with PREADY on a write to addr 0xFF: rsp_err = 1 and the FSM continues.
- Assert PRESETn low in mid-ACCESS with 2 entries queued:
  - PSEL and PENABLE drop immediately, busy = 0 and req_ready = 1.
  - No rsp_valid is generated.
  - Operation resumes normally after release.

Source files
------------

// File: rtl/apb_timer_master.sv
// rtl/apb_timer_master.sv - APB3 requester with request FIFO and ACCESS timeout
module apb_timer_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ADDR_W + DATA_W + 1;
  // Timeout counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [TW-1:0]   tcnt_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            xfer_done, timeout_hit;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign req_ready  = !fifo_full;
  assign push       = req_valid && !fifo_full;
  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign PSEL       = (state_q != S_IDLE);
  assign PENABLE    = (state_q == S_ACCESS);

  // Terminate on the edge that would otherwise start ACCESS cycle TIMEOUT+1.
  assign timeout_hit = TO_EN && (state_q == S_ACCESS) && !PREADY && (tcnt_q == TO_LAST);

  // Next-state and pop decision; a completing transfer chains straight into SETUP.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    xfer_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY || timeout_hit) begin
          xfer_done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr_q] <= {req_write, req_addr, req_wdata};
  end

  // APB address/control/data registered at pop and held until the next pop.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (pop) begin
      {PWRITE, PADDR, PWDATA} <= mem[rd_ptr_q];
    end
  end

  // ACCESS wait-state counter, cleared in SETUP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tcnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      tcnt_q <= '0;
    end else if ((state_q == S_ACCESS) && !PREADY) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Response pulse; data and error hold until the next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= xfer_done;
      if (xfer_done) begin
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err   <= timeout_hit ? 1'b1 : PSLVERR;
      end
    end
  end

endmodule

// File: tb/tb_apb_timer_master.sv
// tb/tb_apb_timer_master.sv - directed self-checking bench for apb_timer_master
module tb_apb_timer_master;

  logic       PCLK, PRESETn;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err, busy;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA;
  logic       PREADY, PSLVERR;

  logic       model_en;
  logic [7:0] prdata_fixed;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [8:0] rsp_q [$];
  int         rsp_t [$];

  apb_timer_master #(.ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave read data: address-derived pattern or a fixed value.
  assign PRDATA = model_en ? (PADDR ^ 8'hA5) : prdata_fixed;

  // Response logger, sampled shortly after each rising edge.
  always @(posedge PCLK) begin
    #2;
    cyc = cyc + 1;
    if (rsp_valid === 1'b1) begin
      rsp_q.push_back({rsp_err, rsp_rdata});
      rsp_t.push_back(cyc);
    end
  end

  task automatic push_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge PCLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b exp 1", req_ready); else passed++;
    checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) $display("FAIL reset_apb_ctrl got %0b exp 000", {PSEL, PENABLE, PWRITE}); else passed++;
    checks++; if ({PADDR, PWDATA} !== 16'h0) $display("FAIL reset_apb_bus got %0h exp 0", {PADDR, PWDATA}); else passed++;
    checks++; if ({rsp_valid, rsp_err, rsp_rdata, busy} !== 11'h0) $display("FAIL reset_rsp_busy got %0h exp 0", {rsp_valid, rsp_err, rsp_rdata, busy}); else passed++;
  endtask

  task automatic test_write_latency;
    int n0;
    n0 = rsp_q.size();
    PREADY = 1'b1;
    push_req(1'b1, 8'h00, 8'h90);
    checks++; if ({PSEL, PENABLE, busy} !== 3'b001) $display("FAIL wr_after_k got %0b exp 001", {PSEL, PENABLE, busy}); else passed++;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE} !== 2'b10) $display("FAIL wr_setup_ctrl got %0b exp 10", {PSEL, PENABLE}); else passed++;
    checks++; if ({PWRITE, PADDR, PWDATA} !== 17'h10090) $display("FAIL wr_setup_bus got %0h exp 10090", {PWRITE, PADDR, PWDATA}); else passed++;
    @(negedge PCLK);
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) $display("FAIL wr_access_ctrl got %0b exp 110", {PSEL, PENABLE, rsp_valid}); else passed++;
    checks++; if ({PWRITE, PADDR, PWDATA} !== 17'h10090) $display("FAIL wr_access_bus got %0h exp 10090", {PWRITE, PADDR, PWDATA}); else passed++;
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err, rsp_rdata, PSEL} !== 11'h400) $display("FAIL wr_rsp got %0h exp 400", {rsp_valid, rsp_err, rsp_rdata, PSEL}); else passed++;
    @(negedge PCLK);
    checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL wr_rsp_pulse got %0b exp 00", {rsp_valid, busy}); else passed++;
    checks++; if (rsp_q.size() - n0 !== 1) $display("FAIL wr_rsp_count got %0d exp 1", rsp_q.size() - n0); else passed++;
  endtask

  task automatic test_read_wait;
    int pen;
    bit bad, seen;
    model_en = 1'b0;
    prdata_fixed = 8'h5A;
    PREADY = 1'b0;
    push_req(1'b0, 8'h02, 8'h00);
    pen = 0; bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
      if (PSEL && (PADDR !== 8'h02 || PWRITE !== 1'b0)) bad = 1'b1;
      if (PENABLE) begin
        pen++;
        if (pen == 4) PREADY = 1'b1;
      end
    end
    checks++; if (seen !== 1'b1) $display("FAIL rd_rsp_seen got %0b exp 1", seen); else passed++;
    checks++; if (pen !== 4) $display("FAIL rd_penable_cycles got %0d exp 4", pen); else passed++;
    checks++; if ({rsp_err, rsp_rdata} !== 9'h05A) $display("FAIL rd_rsp_data got %0h exp 05a", {rsp_err, rsp_rdata}); else passed++;
    checks++; if (bad !== 1'b0) $display("FAIL rd_paddr_stable got %0b exp 0", bad); else passed++;
    model_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    bit bad;
    rsp_q.delete(); rsp_t.delete();
    PREADY = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (req_ready !== 1'b1) bad = 1'b1;
      push_req(1'b0, 8'h10 + 8'(i), 8'h00);
    end
    checks++; if (bad !== 1'b0) $display("FAIL b2b_accept_five got %0b exp 0", bad); else passed++;
    checks++; if ({req_ready, busy} !== 2'b01) $display("FAIL b2b_full got %0b exp 01", {req_ready, busy}); else passed++;
    push_req(1'b0, 8'h1F, 8'h00);
    PREADY = 1'b1;
    for (int i = 0; i < 30 && busy !== 1'b0; i++) @(negedge PCLK);
    checks++; if (busy !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", busy); else passed++;
    checks++; if (rsp_q.size() !== 5) $display("FAIL b2b_rsp_count got %0d exp 5", rsp_q.size()); else passed++;
    for (int i = 0; i < 5 && i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== {1'b0, (8'h10 + 8'(i)) ^ 8'hA5}) $display("FAIL b2b_order%0d got %0h exp %0h", i, rsp_q[i], {1'b0, (8'h10 + 8'(i)) ^ 8'hA5});
      else passed++;
    end
    for (int i = 1; i < 5 && i < rsp_t.size(); i++) begin
      checks++;
      if (rsp_t[i] - rsp_t[i-1] !== 2) $display("FAIL b2b_gap%0d got %0d exp 2", i, rsp_t[i] - rsp_t[i-1]);
      else passed++;
    end
  endtask

  task automatic test_timeout;
    int acc;
    bit seen;
    model_en = 1'b0;
    prdata_fixed = 8'hEE;
    PREADY = 1'b0;
    push_req(1'b0, 8'h30, 8'h00);
    push_req(1'b1, 8'h31, 8'h77);
    acc = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
      if (PENABLE) acc++;
    end
    checks++; if (seen !== 1'b1) $display("FAIL to_rsp_seen got %0b exp 1", seen); else passed++;
    checks++; if (acc !== 16) $display("FAIL to_access_cycles got %0d exp 16", acc); else passed++;
    checks++; if ({rsp_err, rsp_rdata} !== 9'h100) $display("FAIL to_rsp got %0h exp 100", {rsp_err, rsp_rdata}); else passed++;
    PREADY = 1'b1;
    wait_rsp(10, seen);
    checks++; if (seen !== 1'b1) $display("FAIL to_next_seen got %0b exp 1", seen); else passed++;
    checks++; if ({rsp_err, rsp_rdata} !== 9'h000) $display("FAIL to_next_rsp got %0h exp 000", {rsp_err, rsp_rdata}); else passed++;
    checks++; if ({PSEL, PWRITE, PADDR, PWDATA} !== 18'h13177) $display("FAIL to_next_hold got %0h exp 13177", {PSEL, PWRITE, PADDR, PWDATA}); else passed++;
    model_en = 1'b1;
  endtask

  task automatic test_slverr;
    bit seen;
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    push_req(1'b1, 8'hFF, 8'h12);
    wait_rsp(10, seen);
    checks++; if ({seen, rsp_err, rsp_rdata} !== 10'h300) $display("FAIL err_rsp got %0h exp 300", {seen, rsp_err, rsp_rdata}); else passed++;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    checks++; if ({rsp_valid, rsp_err} !== 2'b01) $display("FAIL err_hold got %0b exp 01", {rsp_valid, rsp_err}); else passed++;
    push_req(1'b0, 8'h05, 8'h00);
    wait_rsp(10, seen);
    checks++; if ({seen, rsp_err, rsp_rdata} !== 10'h2A0) $display("FAIL err_continue got %0h exp 2a0", {seen, rsp_err, rsp_rdata}); else passed++;
  endtask

  task automatic test_reset_mid;
    int n0;
    bit seen;
    PREADY = 1'b0;
    push_req(1'b0, 8'h20, 8'h00);
    push_req(1'b1, 8'h21, 8'h01);
    push_req(1'b1, 8'h22, 8'h02);
    checks++; if ({PSEL, PENABLE, req_ready} !== 3'b111) $display("FAIL rst_pre_access got %0b exp 111", {PSEL, PENABLE, req_ready}); else passed++;
    n0 = rsp_q.size();
    #1 PRESETn = 1'b0;
    #1;
    checks++; if ({PSEL, PENABLE, busy, req_ready, rsp_valid} !== 5'b00010) $display("FAIL rst_async got %0b exp 00010", {PSEL, PENABLE, busy, req_ready, rsp_valid}); else passed++;
    checks++; if ({PADDR, PWDATA, PWRITE} !== 17'h0) $display("FAIL rst_async_bus got %0h exp 0", {PADDR, PWDATA, PWRITE}); else passed++;
    PREADY = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);
    checks++; if (rsp_q.size() - n0 !== 0) $display("FAIL rst_no_rsp got %0d exp 0", rsp_q.size() - n0); else passed++;
    checks++; if ({busy, PSEL} !== 2'b00) $display("FAIL rst_idle got %0b exp 00", {busy, PSEL}); else passed++;
    push_req(1'b1, 8'h40, 8'h3C);
    wait_rsp(10, seen);
    checks++; if ({seen, rsp_err, rsp_rdata} !== 10'h200) $display("FAIL rst_resume got %0h exp 200", {seen, rsp_err, rsp_rdata}); else passed++;
    checks++; if ({PADDR, PWDATA} !== 16'h403C) $display("FAIL rst_resume_bus got %0h exp 403c", {PADDR, PWDATA}); else passed++;
  endtask

  initial begin
    PRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    PREADY = 1'b1; PSLVERR = 1'b0;
    model_en = 1'b1; prdata_fixed = 8'h00;
    repeat (3) @(negedge PCLK);
    test_reset;
    PRESETn = 1'b1;
    @(negedge PCLK);
    test_write_latency;
    test_read_wait;
    test_back_to_back;
    test_timeout;
    test_slverr;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
